// File: rtl/smoldvi_pattern_gen.sv
// Test-pattern source for the smoldvi encoder: walks an active raster one sample per
// rgb_rdy and renders gradient, colour bars, checkerboard or flat grey.
module smoldvi_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int PIX_REPEAT = 2,
    parameter int W          = 8,
    parameter int FRAME_W    = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                        clk_pix,
    input  logic                        rst_n_pix,
    input  logic                        en,
    input  logic [1:0]                  mode,
    input  logic                        rgb_rdy,
    output logic [W-1:0]                r,
    output logic [W-1:0]                g,
    output logic [W-1:0]                b,
    output logic [$clog2(H_ACTIVE)-1:0] x,
    output logic [$clog2(V_ACTIVE)-1:0] y,
    output logic [FRAME_W-1:0]          frame,
    output logic                        sof,
    output logic                        eol,
    output logic [1:0]                  active_mode
);

    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int BAR_LEN = H_ACTIVE / 8;
    localparam int BPW     = $clog2(BAR_LEN + 1);
    // Wide enough that every pattern operand fits without loss before truncation to W.
    localparam int SW      = XW + YW + FRAME_W + W + 2;
    localparam int CW      = XW + YW + CHECK_LOG2 + 1;

    localparam logic [XW-1:0]  X_LAST  = XW'(H_ACTIVE - PIX_REPEAT);
    localparam logic [XW-1:0]  X_STEP  = XW'(PIX_REPEAT);
    localparam logic [YW-1:0]  Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [BPW-1:0] BP_LAST = BPW'(BAR_LEN - PIX_REPEAT);
    localparam logic [BPW-1:0] BP_STEP = BPW'(PIX_REPEAT);

    if (((H_ACTIVE % (8 * PIX_REPEAT)) != 0) ||
        ((PIX_REPEAT != 1) && (PIX_REPEAT != 2) && (PIX_REPEAT != 4))) begin : g_param_err
        $error("smoldvi_pattern_gen: PIX_REPEAT must be 1/2/4 and H_ACTIVE a multiple of 8*PIX_REPEAT");
    end

    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [1:0]         mode_q, mode_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [BPW-1:0]     bar_pos_q, bar_pos_d;

    // Raster, bar tracking, frame counter and deferred mode latch.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        frame_d   = frame_q;
        mode_d    = mode_q;
        bar_idx_d = bar_idx_q;
        bar_pos_d = bar_pos_q;
        if (!en) begin
            x_d       = '0;
            y_d       = '0;
            bar_idx_d = 3'd0;
            bar_pos_d = '0;
            mode_d    = mode;
        end else if (rgb_rdy) begin
            if (x_q != X_LAST) begin
                x_d = x_q + X_STEP;
                // Bar boundaries are tracked incrementally so no divide by H_ACTIVE/8 is needed.
                if (bar_pos_q == BP_LAST) begin
                    bar_pos_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_pos_d = bar_pos_q + BP_STEP;
                end
            end else begin
                x_d       = '0;
                bar_idx_d = 3'd0;
                bar_pos_d = '0;
                if (y_q != Y_LAST) begin
                    y_d = y_q + YW'(1);
                end else begin
                    y_d     = '0;
                    frame_d = frame_q + FRAME_W'(1);
                    mode_d  = mode;
                end
            end
        end else begin
            mode_d = mode_q;
        end
    end

    // State register.
    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            x_q       <= '0;
            y_q       <= '0;
            frame_q   <= '0;
            mode_q    <= 2'd0;
            bar_idx_q <= 3'd0;
            bar_pos_q <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            frame_q   <= frame_d;
            mode_q    <= mode_d;
            bar_idx_q <= bar_idx_d;
            bar_pos_q <= bar_pos_d;
        end
    end

    logic [2:0] bar_c_s;
    logic       check_t_s;

    // Pattern rendering; only en reaches the outputs combinationally (through sof).
    always_comb begin
        bar_c_s   = 3'd7 - bar_idx_q;
        check_t_s = (((CW'(x_q) >> CHECK_LOG2) & CW'(1)) != '0) ^
                    (((CW'(y_q) >> CHECK_LOG2) & CW'(1)) != '0) ^ frame_q[0];
        r = '0;
        g = '0;
        b = '0;
        case (mode_q)
            2'd0: begin
                r = W'(SW'(x_q) + SW'(frame_q));
                g = W'(SW'(y_q) + (SW'(frame_q) << 1));
                b = W'(SW'(frame_q));
            end
            2'd1: begin
                r = {W{bar_c_s[1]}};
                g = {W{bar_c_s[2]}};
                b = {W{bar_c_s[0]}};
            end
            2'd2: begin
                r = {W{check_t_s}};
                g = {W{check_t_s}};
                b = {W{check_t_s}};
            end
            2'd3: begin
                r = W'(SW'(frame_q));
                g = W'(SW'(frame_q));
                b = W'(SW'(frame_q));
            end
            default: begin
                r = '0;
                g = '0;
                b = '0;
            end
        endcase
        x           = x_q;
        y           = y_q;
        frame       = frame_q;
        active_mode = mode_q;
        sof         = en && (x_q == '0) && (y_q == '0);
        eol         = (x_q == X_LAST);
    end

endmodule

// File: tb/tb_smoldvi_pattern_gen.sv
// Bench for smoldvi_pattern_gen: a reduced-height raster checked sample by sample against
// a reference model, plus directed checks and a tiny grey-pattern instance.
module tb_smoldvi_pattern_gen;

    localparam int H  = 640;
    localparam int V  = 40;
    localparam int PR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en, rgb_rdy;
    logic [1:0] mode;
    logic [7:0] r, g, b;
    logic [9:0] x;
    logic [5:0] y;
    logic [7:0] frame;
    logic       sof, eol;
    logic [1:0] am;

    logic       en_b, rdy_b;
    logic [1:0] mode_b;
    logic [3:0] r_b, g_b, b_b, x_b;
    logic [1:0] y_b, am_b;
    logic [2:0] frame_b;
    logic       sof_b, eol_b;

    smoldvi_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_REPEAT(PR), .W(8), .FRAME_W(8), .CHECK_LOG2(5)) dut (
        .clk_pix(clk), .rst_n_pix(rst_n), .en(en), .mode(mode), .rgb_rdy(rgb_rdy),
        .r(r), .g(g), .b(b), .x(x), .y(y), .frame(frame), .sof(sof), .eol(eol), .active_mode(am)
    );

    smoldvi_pattern_gen #(.H_ACTIVE(16), .V_ACTIVE(4), .PIX_REPEAT(1), .W(4), .FRAME_W(3)) dut_b (
        .clk_pix(clk), .rst_n_pix(rst_n), .en(en_b), .mode(mode_b), .rgb_rdy(rdy_b),
        .r(r_b), .g(g_b), .b(b_b), .x(x_b), .y(y_b), .frame(frame_b), .sof(sof_b), .eol(eol_b),
        .active_mode(am_b)
    );

    int total = 0;
    int bad   = 0;

    int         m_x, m_y, m_frame;
    logic [1:0] m_mode;
    logic [51:0] sb_q[$];

    function automatic logic [51:0] expect_now();
        logic [7:0] er, eg, eb;
        logic [2:0] c;
        logic       t;
        case (m_mode)
            2'd0: begin
                er = 8'(m_x + m_frame);
                eg = 8'(m_y + 2 * m_frame);
                eb = 8'(m_frame);
            end
            2'd1: begin
                c  = 3'(7 - (m_x / (H / 8)));
                er = {8{c[1]}};
                eg = {8{c[2]}};
                eb = {8{c[0]}};
            end
            2'd2: begin
                t  = 1'(((m_x / 32) % 2) ^ ((m_y / 32) % 2) ^ (m_frame % 2));
                er = {8{t}};
                eg = {8{t}};
                eb = {8{t}};
            end
            default: begin
                er = 8'(m_frame);
                eg = 8'(m_frame);
                eb = 8'(m_frame);
            end
        endcase
        return {er, eg, eb, 10'(m_x), 6'(m_y), 8'(m_frame),
                (m_x == 0 && m_y == 0 && en == 1'b1), (m_x == H - PR), m_mode};
    endfunction

    task automatic model_step();
        if (!en) begin
            m_x = 0;
            m_y = 0;
            m_mode = mode;
        end else if (rgb_rdy) begin
            if (m_x == H - PR) begin
                m_x = 0;
                if (m_y == V - 1) begin
                    m_y = 0;
                    m_frame = (m_frame + 1) % 256;
                    m_mode = mode;
                end else begin
                    m_y = m_y + 1;
                end
            end else begin
                m_x = m_x + PR;
            end
        end
    endtask

    // One pixel-clock cycle: push the model's sample, compare DUT output, advance both.
    task automatic cycle(input logic rdy);
        logic [51:0] exp_v, got;
        rgb_rdy = rdy;
        #1;
        sb_q.push_back(expect_now());
        got   = {r, g, b, x, y, frame, sof, eol, am};
        exp_v = sb_q.pop_front();
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL sample(x=%0d,y=%0d): got %h want %h", m_x, m_y, got, exp_v);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_frame = 0; m_mode = 2'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if ({x, y, frame, am} !== {10'd0, 6'd0, 8'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_a: got x=%0d y=%0d f=%0d m=%0d want 0", x, y, frame, am);
        end
        total++;
        if ({x_b, y_b, frame_b, am_b} !== {4'd0, 2'd0, 3'd0, 2'd0}) begin
            bad++;
            $display("FAIL reset_b: got x=%0d y=%0d f=%0d m=%0d want 0", x_b, y_b, frame_b, am_b);
        end
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_gradient();
        mode = 2'd0;
        en   = 1'b1;
        for (int i = 0; i < (H / PR) * V; i++) begin
            #1;
            if (i == 0) begin
                total++;
                if ({r, g, b, sof} !== {8'd0, 8'd0, 8'd0, 1'b1}) begin
                    bad++;
                    $display("FAIL grad_first: got %h %h %h sof=%b want 0 0 0 1", r, g, b, sof);
                end
            end
            if (i == 5) begin
                total++;
                if ({x, r} !== {10'd10, 8'd10}) begin
                    bad++;
                    $display("FAIL grad_s5: got x=%0d r=%0d want 10 10", x, r);
                end
            end
            if (i == 319) begin
                total++;
                if ({x, eol} !== {10'd638, 1'b1}) begin
                    bad++;
                    $display("FAIL grad_eol: got x=%0d eol=%b want 638 1", x, eol);
                end
            end
            cycle(1'b1);
        end
        #1;
        total++;
        if ({frame, sof, r, g, b} !== {8'd1, 1'b1, 8'd1, 8'd2, 8'd1}) begin
            bad++;
            $display("FAIL grad_wrap: got f=%0d sof=%b rgb=%h %h %h want 1 1 01 02 01", frame, sof, r, g, b);
        end
    endtask

    task automatic test_rdy_toggle();
        int exp_x[5] = '{0, 2, 2, 4, 4};
        int n = 0;
        int i = 0;
        do_reset();
        en = 1'b1;
        while (n < (H / PR) * V - 1) begin
            logic rr;
            rr = (i % 2 == 0);
            if (i < 5) begin
                #1;
                total++;
                if (x !== 10'(exp_x[i])) begin
                    bad++;
                    $display("FAIL rdy_x[%0d]: got %0d want %0d", i, x, exp_x[i]);
                end
            end
            cycle(rr);
            if (rr) n++;
            i++;
        end
        cycle(1'b0);
        #1;
        total++;
        if (frame !== 8'd0) begin
            bad++;
            $display("FAIL rdy_prewrap: got frame=%0d want 0", frame);
        end
        cycle(1'b1);
        #1;
        total++;
        if ({frame, x, y} !== {8'd1, 10'd0, 6'd0}) begin
            bad++;
            $display("FAIL rdy_wrap: got f=%0d x=%0d y=%0d want 1 0 0", frame, x, y);
        end
    endtask

    task automatic test_bars();
        logic [23:0] exp_rgb;
        do_reset();
        en   = 1'b0;
        mode = 2'd1;
        cycle(1'b1);
        cycle(1'b1);
        #1;
        total++;
        if (am !== 2'd1) begin
            bad++;
            $display("FAIL bars_mode: got %0d want 1", am);
        end
        en = 1'b1;
        for (int i = 0; i <= 320; i++) begin
            if (i == 0 || i == 40 || i == 80 || i == 280 || i == 320) begin
                case (i)
                    40:      exp_rgb = 24'hFFFF00;
                    80:      exp_rgb = 24'h00FFFF;
                    280:     exp_rgb = 24'h000000;
                    default: exp_rgb = 24'hFFFFFF;
                endcase
                #1;
                total++;
                if ({r, g, b} !== exp_rgb) begin
                    bad++;
                    $display("FAIL bars_s%0d: got %h%h%h want %h", i, r, g, b, exp_rgb);
                end
            end
            cycle(1'b1);
        end
    endtask

    task automatic test_mode_change();
        do_reset();
        mode = 2'd0;
        en   = 1'b1;
        for (int i = 0; i <= (H / PR) * V + 16; i++) begin
            if (i == 30 * (H / PR)) mode = 2'd2;
            if (i == (H / PR) * V - 1) begin
                #1;
                total++;
                if (am !== 2'd0) begin
                    bad++;
                    $display("FAIL mc_deferred: got mode=%0d want 0", am);
                end
            end
            if (i == (H / PR) * V) begin
                #1;
                total++;
                if ({am, frame, sof, r, g, b} !== {2'd2, 8'd1, 1'b1, 24'hFFFFFF}) begin
                    bad++;
                    $display("FAIL mc_sof: got m=%0d f=%0d sof=%b rgb=%h%h%h want 2 1 1 ffffff",
                             am, frame, sof, r, g, b);
                end
            end
            if (i == (H / PR) * V + 16) begin
                #1;
                total++;
                if ({x, y, r, g, b} !== {10'd32, 6'd0, 24'h000000}) begin
                    bad++;
                    $display("FAIL mc_x32: got x=%0d y=%0d rgb=%h%h%h want 32 0 000000", x, y, r, g, b);
                end
            end
            cycle(1'b1);
        end
    endtask

    task automatic test_en_drop();
        int guard = 0;
        while (!(m_x == 200 && m_y == 20) && guard < 20000) begin
            cycle(1'b1);
            guard++;
        end
        #1;
        total++;
        if ({x, y, frame} !== {10'd200, 6'd20, 8'd1}) begin
            bad++;
            $display("FAIL en_pos: got x=%0d y=%0d f=%0d want 200 20 1", x, y, frame);
        end
        en   = 1'b0;
        mode = 2'd3;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        en = 1'b1;
        #1;
        total++;
        if ({x, y, sof, frame, am} !== {10'd0, 6'd0, 1'b1, 8'd1, 2'd3}) begin
            bad++;
            $display("FAIL en_restart: got x=%0d y=%0d sof=%b f=%0d m=%0d want 0 0 1 1 3", x, y, sof, frame, am);
        end
        for (int i = 0; i < 150; i++) cycle(1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({x, y, frame, am} !== {10'd0, 6'd0, 8'd0, 2'd0}) begin
            bad++;
            $display("FAIL async_rst: got x=%0d y=%0d f=%0d m=%0d want 0", x, y, frame, am);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_small();
        en_b   = 1'b0;
        mode_b = 2'd3;
        rdy_b  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_b = 1'b1;
        for (int i = 0; i <= 512; i++) begin
            #1;
            if (i == 15) begin
                total++;
                if ({x_b, eol_b} !== {4'd15, 1'b1}) begin
                    bad++;
                    $display("FAIL small_eol: got x=%0d eol=%b want 15 1", x_b, eol_b);
                end
            end
            if (i == 64) begin
                total++;
                if ({am_b, frame_b, r_b, g_b, b_b} !== {2'd3, 3'd1, 4'd1, 4'd1, 4'd1}) begin
                    bad++;
                    $display("FAIL small_f1: got m=%0d f=%0d rgb=%h%h%h want 3 1 111", am_b, frame_b, r_b, g_b, b_b);
                end
            end
            if (i == 448) begin
                total++;
                if ({frame_b, r_b} !== {3'd7, 4'd7}) begin
                    bad++;
                    $display("FAIL small_f7: got f=%0d r=%0d want 7 7", frame_b, r_b);
                end
            end
            if (i == 512) begin
                total++;
                if ({frame_b, r_b, sof_b} !== {3'd0, 4'd0, 1'b1}) begin
                    bad++;
                    $display("FAIL small_wrap: got f=%0d r=%0d sof=%b want 0 0 1", frame_b, r_b, sof_b);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        mode    = 2'd0;
        rgb_rdy = 1'b0;
        en_b    = 1'b0;
        mode_b  = 2'd0;
        rdy_b   = 1'b0;
        model_reset();
        test_reset();
        test_gradient();
        test_rdy_toggle();
        test_bars();
        test_mode_change();
        test_en_drop();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
